// File: rtl/clint_axi_bridge.sv
// AXI4 slave front end for the core-local interrupt controller: one burst at a time is
// turned into single-cycle register strobes (address_o/en_o/we_o/be_o/data_o/data_i).
module clint_axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // AXI channels: a beat transfers on a rising edge where valid and ready are both 1;
  // the slave never takes back a ready it raised, and holds R/B payloads until accepted.
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [63:0]               w_data_i,
  input  logic [7:0]                w_strb_i,
  input  logic                      w_last_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [63:0]               r_data_o,
  output logic [AXI_ID_WIDTH-1:0]   r_id_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]                b_resp_o,
  output logic [AXI_ADDR_WIDTH-1:0] address_o,
  output logic                      en_o,
  output logic                      we_o,
  output logic [7:0]                be_o,
  output logic [63:0]               data_o,
  input  logic [63:0]               data_i,
  output logic [2:0]                state_o
);

  if (AXI_DATA_WIDTH != 64) begin : g_width_check
    $fatal(1, "clint_axi_bridge: only AXI_DATA_WIDTH = 64 is supported");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_RESP  = 3'd2,
    WR_DATA  = 3'd3,
    WR_RESP  = 3'd4
  } state_e;

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(7);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(8);

  state_e                    state_q, state_d;
  prio_e                     prio_q, prio_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                beat_q, beat_d;
  logic [63:0]               r_data_q, r_data_d;
  logic                      r_last_q, r_last_d;

  // Write bursts end on w_last_i alone, so the announced length carries no information here.
  logic unused_aw_len;
  assign unused_aw_len = ^aw_len_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      prio_q   <= PRIO_RD;
      addr_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      beat_q   <= '0;
      r_data_q <= '0;
      r_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      id_q     <= id_d;
      beat_q   <= beat_d;
      r_data_q <= r_data_d;
      r_last_q <= r_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    beat_d     = beat_q;
    r_data_d   = r_data_q;
    r_last_d   = r_last_q;
    ar_ready_o = 1'b0;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    r_valid_o  = 1'b0;
    b_valid_o  = 1'b0;
    en_o       = 1'b0;
    we_o       = 1'b0;
    be_o       = 8'h00;
    data_o     = 64'h0;

    unique case (state_q)
      IDLE: begin
        // Readies are gated by reset so nothing is granted while rst_ni is low.
        ar_ready_o = rst_ni && ar_valid_i && (!aw_valid_i || prio_q == PRIO_RD);
        aw_ready_o = rst_ni && aw_valid_i && (!ar_valid_i || prio_q == PRIO_WR);
        if (ar_ready_o) begin
          addr_d  = ar_addr_i & ALIGN_MASK;
          len_d   = ar_len_i;
          id_d    = ar_id_i;
          beat_d  = 8'd0;
          prio_d  = PRIO_WR;
          state_d = RD_ISSUE;
        end else if (aw_ready_o) begin
          addr_d  = aw_addr_i & ALIGN_MASK;
          id_d    = aw_id_i;
          prio_d  = PRIO_RD;
          state_d = WR_DATA;
        end
      end
      RD_ISSUE: begin
        en_o     = 1'b1;
        be_o     = 8'hFF;
        r_data_d = data_i;
        r_last_d = (beat_q == len_q);
        state_d  = RD_RESP;
      end
      RD_RESP: begin
        r_valid_o = 1'b1;
        if (r_ready_i) begin
          if (r_last_q) begin
            beat_d   = 8'd0;
            r_last_d = 1'b0;
            state_d  = IDLE;
          end else begin
            addr_d  = addr_q + BEAT_BYTES;
            beat_d  = beat_q + 8'd1;
            state_d = RD_ISSUE;
          end
        end
      end
      WR_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          en_o   = 1'b1;
          we_o   = 1'b1;
          be_o   = w_strb_i;
          data_o = w_data_i;
          addr_d = addr_q + BEAT_BYTES;
          if (w_last_i) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign address_o = addr_q;
  assign r_data_o  = r_data_q;
  assign r_last_o  = r_last_q;
  assign r_id_o    = id_q;
  assign b_id_o    = id_q;
  assign r_resp_o  = 2'b00;
  assign b_resp_o  = 2'b00;
  assign state_o   = state_q;

endmodule

// File: tb/tb_clint_axi_bridge.sv
// Bench for clint_axi_bridge: an AXI master driver, a register-file responder on data_i,
// and scoreboards of expected strobes and R/B beats computed from address arithmetic.
`timescale 1ns/1ps
module tb_clint_axi_bridge;

  localparam int AW = 64;
  localparam int IW = 10;
  localparam int ACC_W = 1 + 8 + 64 + 64;  // {we, be, address, write data}
  localparam int RB_W  = IW + 1 + 2 + 64;  // {id, last, resp, data}
  localparam int BB_W  = IW + 2;           // {id, resp}

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          ar_valid_i, ar_ready_o, aw_valid_i, aw_ready_o;
  logic [AW-1:0] ar_addr_i, aw_addr_i, address_o;
  logic [7:0]    ar_len_i, aw_len_i, w_strb_i, be_o;
  logic [IW-1:0] ar_id_i, aw_id_i, r_id_o, b_id_o;
  logic          w_valid_i, w_ready_o, w_last_i;
  logic [63:0]   w_data_i, r_data_o, data_o, data_i;
  logic          r_valid_o, r_ready_i, r_last_o, b_valid_o, b_ready_i, en_o, we_o;
  logic [1:0]    r_resp_o, b_resp_o;
  logic [2:0]    state_o;

  clint_axi_bridge #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_DATA_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .address_o(address_o), .en_o(en_o), .we_o(we_o), .be_o(be_o), .data_o(data_o),
    .data_i(data_i), .state_o(state_o)
  );

  // ---------------- register file responder / reference ----------------
  logic [63:0] salt;
  function automatic logic [63:0] rf_value(input logic [63:0] a, input logic [63:0] s);
    if (a == 64'hBFF8) return 64'h1122334455667788;
    return {a[31:0] ^ s[31:0], ~a[31:0] ^ s[63:32]};
  endfunction
  assign data_i = (en_o && !we_o) ? rf_value(address_o, salt) : 64'hDEAD_BEEF_0BAD_F00D;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] obs_q[$];
  logic [RB_W-1:0]  exp_r_q[$];
  logic [RB_W-1:0]  rbeat_q[$];
  logic [BB_W-1:0]  exp_b_q[$];
  logic [BB_W-1:0]  b_q[$];
  logic             grant_q[$];
  int               both_ready = 0;
  int               stall_changes = 0;
  logic [63:0]      wd[256];
  logic [7:0]       ws[256];

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (en_o) obs_q.push_back({we_o, be_o, address_o, we_o ? data_o : 64'h0});
      if (ar_ready_o && aw_ready_o) both_ready++;
      if (ar_valid_i && ar_ready_o) grant_q.push_back(1'b0);
      if (aw_valid_i && aw_ready_o) grant_q.push_back(1'b1);
    end
  end

  // Model: INCR bursts of 8-byte beats from the 8-byte-aligned start, wrapping at 2^64.
  function automatic void expect_read(input logic [63:0] a, input int len, input logic [IW-1:0] id);
    logic [63:0] cur;
    for (int i = 0; i <= len; i++) begin
      cur = (a & ~64'h7) + 64'(i) * 64'd8;
      exp_q.push_back({1'b0, 8'hFF, cur, 64'h0});
      exp_r_q.push_back({id, (i == len), 2'b00, rf_value(cur, salt)});
    end
  endfunction

  function automatic void expect_write(input logic [63:0] a, input logic [IW-1:0] id, input int n);
    logic [63:0] cur;
    for (int i = 0; i < n; i++) begin
      cur = (a & ~64'h7) + 64'(i) * 64'd8;
      exp_q.push_back({1'b1, ws[i], cur, wd[i]});
    end
    exp_b_q.push_back({id, 2'b00});
  endfunction

  function automatic void clear_all();
    exp_q.delete(); obs_q.delete(); exp_r_q.delete(); rbeat_q.delete();
    exp_b_q.delete(); b_q.delete(); grant_q.delete();
    both_ready = 0; stall_changes = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_ni = 1'b0;
    ar_valid_i = 0; ar_addr_i = '0; ar_len_i = '0; ar_id_i = '0;
    aw_valid_i = 0; aw_addr_i = '0; aw_len_i = '0; aw_id_i = '0;
    w_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_last_i = 0;
    r_ready_i = 0; b_ready_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic send_ar(input logic [63:0] a, input logic [7:0] len, input logic [IW-1:0] id,
                         output bit ok);
    int guard = 0;
    ok = 0;
    @(posedge clk_i); #1;
    ar_valid_i = 1; ar_addr_i = a; ar_len_i = len; ar_id_i = id;
    while (!ok && guard < 400) begin
      @(negedge clk_i);
      if (ar_ready_o) ok = 1; else guard++;
    end
    @(posedge clk_i); #1;
    ar_valid_i = 0;
  endtask

  task automatic recv_r(input int n, input int mode, output bit ok);
    int got = 0;
    int guard = 0;
    bit have_prev = 0;
    logic [RB_W-1:0] prev, cur;
    prev = '0;
    while (got < n && guard < 5000) begin
      @(posedge clk_i); #1;
      case (mode)
        0:       r_ready_i = 1'b1;
        1:       r_ready_i = (guard % 2 == 0);
        default: r_ready_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk_i);
      if (r_valid_o) begin
        cur = {r_id_o, r_last_o, r_resp_o, r_data_o};
        if (have_prev && cur !== prev) stall_changes++;
        if (r_ready_i) begin
          rbeat_q.push_back(cur); got++; have_prev = 0;
        end else begin
          prev = cur; have_prev = 1;
        end
      end
      guard++;
    end
    @(posedge clk_i); #1;
    r_ready_i = 0;
    ok = (got == n);
  endtask

  task automatic axi_read(input logic [63:0] a, input logic [7:0] len, input logic [IW-1:0] id,
                          input int mode, output bit ok);
    bit aok, rok;
    send_ar(a, len, id, aok);
    rok = 0;
    if (aok) recv_r(int'(len) + 1, mode, rok);
    ok = aok && rok;
  endtask

  task automatic axi_write(input logic [63:0] a, input logic [IW-1:0] id, input int n,
                           input bit gaps, output bit ok);
    int i = 0;
    int guard = 0;
    bit aok = 0;
    bit got = 0;
    @(posedge clk_i); #1;
    aw_valid_i = 1; aw_addr_i = a; aw_id_i = id; aw_len_i = 8'(n - 1);
    while (!aok && guard < 400) begin
      @(negedge clk_i);
      if (aw_ready_o) aok = 1; else guard++;
    end
    @(posedge clk_i); #1;
    aw_valid_i = 0;
    guard = 0;
    while (aok && i < n && guard < 3000) begin
      w_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_data_i = wd[i]; w_strb_i = ws[i]; w_last_i = (i == n - 1);
      @(negedge clk_i);
      if (w_valid_i && w_ready_o) i++;
      guard++;
      @(posedge clk_i); #1;
    end
    w_valid_i = 0; w_last_i = 0;
    guard = 0;
    while (aok && !got && guard < 400) begin
      b_ready_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_i);
      if (b_valid_o && b_ready_i) begin
        b_q.push_back({b_id_o, b_resp_o}); got = 1;
      end
      guard++;
      @(posedge clk_i); #1;
    end
    b_ready_i = 0;
    ok = aok && (i == n) && got;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    ar_valid_i = 1; aw_valid_i = 1; w_valid_i = 1;
    @(negedge clk_i);
    total++;
    if ({ar_ready_o, aw_ready_o, w_ready_o, r_valid_o, b_valid_o, en_o, we_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {ar_ready_o, aw_ready_o, w_ready_o, r_valid_o, b_valid_o, en_o, we_o});
    end
    do_reset();
    @(negedge clk_i);
    total++;
    if ({address_o, data_o, be_o} !== '0) begin
      bad++; $display("FAIL reset_strobe got=%h/%h/%h exp=0", address_o, data_o, be_o);
    end
    total++;
    if ({r_data_o, r_id_o, b_id_o, r_last_o, r_resp_o, b_resp_o} !== '0) begin
      bad++; $display("FAIL reset_resp got=%h/%h/%h/%b exp=0", r_data_o, r_id_o, b_id_o, r_last_o);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    clear_all();
    axi_read(64'hBFF8, 8'd0, 10'd5, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_read_timeout got=0 exp=1"); end
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 8'hFF, 64'hBFF8, 64'h0}) begin
      bad++; $display("FAIL single_read_strobe n=%0d got=%h exp=%h", obs_q.size(),
                      (obs_q.size() > 0) ? obs_q[0] : '0, {1'b0, 8'hFF, 64'hBFF8, 64'h0});
    end
    total++;
    if (rbeat_q.size() != 1 || rbeat_q[0] !== {10'd5, 1'b1, 2'b00, 64'h1122334455667788}) begin
      bad++; $display("FAIL single_read_beat n=%0d got=%h exp=%h", rbeat_q.size(),
                      (rbeat_q.size() > 0) ? rbeat_q[0] : '0, {10'd5, 1'b1, 2'b00, 64'h1122334455667788});
    end
  endtask

  task automatic test_single_write();
    bit ok;
    clear_all();
    wd[0] = 64'hDEAD; ws[0] = 8'hFF;
    axi_write(64'h4000, 10'd3, 1, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_write_timeout got=0 exp=1"); end
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 8'hFF, 64'h4000, 64'hDEAD}) begin
      bad++; $display("FAIL single_write_strobe n=%0d got=%h exp=%h", obs_q.size(),
                      (obs_q.size() > 0) ? obs_q[0] : '0, {1'b1, 8'hFF, 64'h4000, 64'hDEAD});
    end
    total++;
    if (b_q.size() != 1 || b_q[0] !== {10'd3, 2'b00}) begin
      bad++; $display("FAIL single_write_b n=%0d got=%h exp=%h", b_q.size(),
                      (b_q.size() > 0) ? b_q[0] : '0, {10'd3, 2'b00});
    end
  endtask

  task automatic test_read_burst();
    bit ok;
    clear_all();
    expect_read(64'h4000, 3, 10'h2A);
    axi_read(64'h4000, 8'd3, 10'h2A, 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL burst_timeout got=0 exp=1"); end
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL burst_en_count got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_strobe idx=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_r_q.size() && i < rbeat_q.size(); i++) begin
      total++;
      if (rbeat_q[i] !== exp_r_q[i]) begin bad++; $display("FAIL burst_beat idx=%0d got=%h exp=%h", i, rbeat_q[i], exp_r_q[i]); end
    end
    total++;
    if (stall_changes != 0) begin bad++; $display("FAIL burst_stall_stable got=%0d exp=0", stall_changes); end
  endtask

  task automatic test_back_to_back();
    bit ok_r1, ok_r2, ok_w1, ok_w2;
    logic [3:0] order;
    do_reset();
    clear_all();
    wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hA5;
    expect_read(64'h1000, 0, 10'd1);
    expect_write(64'h2000, 10'd2, 1);
    expect_read(64'h1008, 0, 10'd3);
    expect_write(64'h2008, 10'd4, 1);
    fork
      begin
        axi_read(64'h1000, 8'd0, 10'd1, 0, ok_r1);
        axi_read(64'h1008, 8'd0, 10'd3, 0, ok_r2);
      end
      begin
        axi_write(64'h2000, 10'd2, 1, 0, ok_w1);
        axi_write(64'h2008, 10'd4, 1, 0, ok_w2);
      end
    join
    total++;
    if (!(ok_r1 && ok_r2 && ok_w1 && ok_w2)) begin
      bad++; $display("FAIL arb_timeout got=%b exp=1111", {ok_r1, ok_r2, ok_w1, ok_w2});
    end
    order = 4'hF;
    for (int i = 0; i < 4 && i < grant_q.size(); i++) order[3 - i] = grant_q[i];
    total++;
    if (grant_q.size() != 4 || order !== 4'b0101) begin
      bad++; $display("FAIL arb_order n=%0d got=%b exp=0101 (0=read)", grant_q.size(), order);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL arb_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL arb_strobe idx=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_b_q.size() && i < b_q.size(); i++) begin
      total++;
      if (b_q[i] !== exp_b_q[i]) begin bad++; $display("FAIL arb_b idx=%0d got=%h exp=%h", i, b_q[i], exp_b_q[i]); end
    end
    total++;
    if (both_ready != 0) begin bad++; $display("FAIL arb_both_ready got=%0d exp=0", both_ready); end
  endtask

  task automatic test_unaligned_write();
    bit ok;
    int early_ready = 0;
    clear_all();
    wd[0] = 64'hCAFE_F00D_1234_5678; ws[0] = 8'h0F;
    @(posedge clk_i); #1;
    w_valid_i = 1; w_data_i = wd[0]; w_strb_i = ws[0]; w_last_i = 1;
    repeat (4) begin
      @(negedge clk_i);
      if (w_ready_o) early_ready++;
    end
    total++;
    if (early_ready != 0 || obs_q.size() != 0) begin
      bad++; $display("FAIL early_w got=%0d/%0d exp=0/0", early_ready, obs_q.size());
    end
    expect_write(64'h4005, 10'd7, 1);
    axi_write(64'h4005, 10'd7, 1, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL unaligned_timeout got=0 exp=1"); end
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL unaligned_strobe n=%0d got=%h exp=%h", obs_q.size(),
                      (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int guard = 0;
    clear_all();
    send_ar(64'h8000, 8'd7, 10'd9, ok);
    while (!r_valid_o && guard < 20) begin @(negedge clk_i); guard++; end
    total++;
    if (!ok || !r_valid_o) begin bad++; $display("FAIL midrst_setup got=%b exp=1", r_valid_o); end
    @(posedge clk_i); #1;
    ar_valid_i = 1; aw_valid_i = 1; w_valid_i = 1; rst_ni = 1'b0;
    @(negedge clk_i);
    total++;
    if ({r_valid_o, ar_ready_o, aw_ready_o, w_ready_o, en_o} !== 5'b0) begin
      bad++; $display("FAIL midrst_outputs got=%b exp=00000", {r_valid_o, ar_ready_o, aw_ready_o, w_ready_o, en_o});
    end
    @(posedge clk_i); #1;
    ar_valid_i = 0; aw_valid_i = 0; w_valid_i = 0; w_last_i = 0;
    rst_ni = 1'b1;
    clear_all();
    expect_read(64'hBFF8, 0, 10'd1);
    axi_read(64'hBFF8, 8'd0, 10'd1, 0, ok);
    total++;
    if (!ok || rbeat_q.size() != 1 || rbeat_q[0] !== exp_r_q[0]) begin
      bad++; $display("FAIL midrst_recover n=%0d got=%h exp=%h", rbeat_q.size(),
                      (rbeat_q.size() > 0) ? rbeat_q[0] : '0, exp_r_q[0]);
    end
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL midrst_en_count got=%0d exp=1", obs_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int fails = 0;
    int len, n;
    logic [63:0] a;
    logic [IW-1:0] id;
    clear_all();
    for (int t = 0; t < 16; t++) begin
      a = {$urandom, $urandom};
      if (t == 0) a = 64'hFFFF_FFFF_FFFF_FFF3;
      id = IW'($urandom);
      if (t % 2 == 0) begin
        len = (t == 4) ? 255 : $urandom_range(0, 15);
        expect_read(a, len, id);
        axi_read(a, 8'(len), id, 2, ok);
      end else begin
        n = (t == 5) ? 256 : $urandom_range(1, 16);
        for (int i = 0; i < n; i++) begin
          wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom);
        end
        expect_write(a, id, n);
        axi_write(a, id, n, 1, ok);
      end
      if (!ok) fails++;
    end
    total++;
    if (fails != 0) begin bad++; $display("FAIL rand_timeout got=%0d exp=0", fails); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_strobe idx=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (rbeat_q.size() != exp_r_q.size()) begin bad++; $display("FAIL rand_rcount got=%0d exp=%0d", rbeat_q.size(), exp_r_q.size()); end
    for (int i = 0; i < exp_r_q.size() && i < rbeat_q.size(); i++) begin
      total++;
      if (rbeat_q[i] !== exp_r_q[i]) begin bad++; $display("FAIL rand_beat idx=%0d got=%h exp=%h", i, rbeat_q[i], exp_r_q[i]); end
    end
    for (int i = 0; i < exp_b_q.size() && i < b_q.size(); i++) begin
      total++;
      if (b_q[i] !== exp_b_q[i]) begin bad++; $display("FAIL rand_b idx=%0d got=%h exp=%h", i, b_q[i], exp_b_q[i]); end
    end
    total++;
    if (stall_changes != 0 || both_ready != 0) begin
      bad++; $display("FAIL rand_stable got=%0d/%0d exp=0/0", stall_changes, both_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    salt = {$urandom, $urandom};
    do_reset();
    test_reset();
    test_single_read();
    test_single_write();
    test_read_burst();
    test_back_to_back();
    test_unaligned_write();
    test_reset_mid_burst();
    test_random();
    repeat (2) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/clint_axi_bridge.md
Name: clint_axi_bridge

Overview:
- Slave-side front end that converts AXI4 read/write transactions into a single-cycle register-access strobe interface (address/en/we/be/wdata/rdata).
- Sits directly upstream of the core-local interrupt controller (mtime/mtimecmp/msip register file) and feeds its register access port.
- Supports INCR bursts of up to 256 beats of 64 bits each, one outstanding transaction at a time, and round-robin arbitration between read and write.

Parameters:
AXI_ADDR_WIDTH, 64, width of AR/AW address and of address_o
AXI_ID_WIDTH, 10, width of transaction IDs echoed on R/B
AXI_DATA_WIDTH, 64, data width; only 64 is supported (elaboration-time fatal otherwise)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
ar_valid_i / ar_ready_o  in/out  1  read address handshake
ar_addr_i  in  AXI_ADDR_WIDTH  read start address
ar_len_i  in  8  read beats minus 1
ar_id_i  in  AXI_ID_WIDTH  read ID
aw_valid_i / aw_ready_o  in/out  1  write address handshake
aw_addr_i  in  AXI_ADDR_WIDTH  write start address
aw_len_i  in  8  write beats minus 1 (informational; w_last_i terminates)
aw_id_i  in  AXI_ID_WIDTH  write ID
w_valid_i / w_ready_o  in/out  1  write data handshake
w_data_i  in  64  write data
w_strb_i  in  8  byte strobes
w_last_i  in  1  last write beat
r_valid_o / r_ready_i  out/in  1  read data handshake
r_data_o  out  64  read data
r_id_o  out  AXI_ID_WIDTH  echoed ID
r_resp_o  out  2  always 2'b00 (OKAY)
r_last_o  out  1  last read beat
b_valid_o / b_ready_i  out/in  1  write response handshake
b_id_o  out  AXI_ID_WIDTH  echoed ID
b_resp_o  out  2  always 2'b00 (OKAY)
address_o  out  AXI_ADDR_WIDTH  register address for the current access
en_o  out  1  access strobe, one cycle per beat
we_o  out  1  1 = write, 0 = read
be_o  out  8  byte enables (w_strb_i on writes, 8'hFF on reads)
data_o  out  64  write data
data_i  in  64  read data, combinational from the register file in the cycle en_o=1 and we_o=0

Behaviour:
- FSM states: IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_RESP. Reset state is IDLE.
- Reset values: all *_valid_o, *_ready_o, en_o and we_o are 0; address_o, data_o, be_o, r_data_o, r_id_o and b_id_o are 0; r_last_o is 0; prio_q = read.
- IDLE:
  - ar_ready_o = 1 when ar_valid_i and (!aw_valid_i or prio_q==read).
  - aw_ready_o = 1 when aw_valid_i and (!ar_valid_i or prio_q==write).
  - Both ready signals are combinational; at most one is 1 in any cycle.
  - On AR handshake: latch addr, len, id; go to RD_ISSUE; prio_q <= write.
  - On AW handshake: latch addr, id; go to WR_DATA; prio_q <= read.
  - prio_q toggles only on a granted handshake.
- RD_ISSUE (1 cycle):
  - en_o=1, we_o=0, be_o=8'hFF, address_o = addr_q.
  - data_i is captured into r_data_o at the clock edge; r_last_o <= (beat_cnt == len_q); go to RD_RESP.
- RD_RESP:
  - r_valid_o=1; r_data_o, r_id_o and r_last_o are held stable until r_ready_i.
  - On handshake: if last, go to IDLE and clear the beat counter. Otherwise addr_q += 8, beat_cnt += 1, go to RD_ISSUE.
  - Read throughput is 1 beat per 2 cycles minimum.
- WR_DATA:
  - w_ready_o=1.
  - On w_valid_i, in the same cycle: en_o=1, we_o=1, be_o=w_strb_i, data_o=w_data_i, address_o=addr_q. en_o is combinational from w_valid_i in this state.
  - Then addr_q += 8. On w_last_i, go to WR_RESP.
  - Write throughput is 1 beat per cycle.
  - aw_len_i is ignored; termination is by w_last_i only.
- WR_RESP:
  - b_valid_o=1 with b_id_o = latched id; held until b_ready_i, then go to IDLE.
- Address arithmetic:
  - The start address is aligned down to 8 bytes (bits [2:0] cleared) before issue.
  - Increment is +8 modulo 2^AXI_ADDR_WIDTH; no 4 KiB boundary check.
- Transaction rules:
  - Only one transaction is in flight.
  - No AR/AW acceptance outside IDLE.
  - No W acceptance outside WR_DATA. W beats arriving before AW are held off by w_ready_o=0.
  - All responses are OKAY. Burst type and size inputs are not present; INCR of 8 bytes is implied.
- Asynchronous reset mid-burst returns to IDLE immediately. No response is produced for the aborted transaction.

Test Plan:
- Single read: AR addr=0xBFF8, id=5, len=0; data_i=0x1122334455667788 in RD_ISSUE -> one en_o pulse with we_o=0 and address_o=0xBFF8; then R beat data=0x1122334455667788, id=5, last=1, resp=0.
- Single write: AW addr=0x4000, id=3; W data=0xDEAD, strb=0xFF, last=1 -> en_o=we_o=1 for one cycle with address_o=0x4000 and data_o=0xDEAD; then B id=3, resp=0.
- Read burst: len=3 from 0x4000, r_ready_i toggling 1-0-1 -> addresses 0x4000, 0x4008, 0x4010, 0x4018, exactly four en_o pulses; r_data_o stable while stalled; r_last_o only on beat 4.
- Simultaneous AR and AW valid, repeated twice back-to-back from reset -> grant order is read, write, read, write. Ready signals are never both 1.
- Unaligned start address 0x4005, write with strb=0x0F -> address_o=0x4000, be_o=0x0F. W presented before AW is not accepted until AW completes.
- Assert rst_ni in RD_RESP of a len=7 burst -> r_valid_o=0 and all ready signals 0 during reset; after release, a new single read completes normally.
